// File: rtl/usb_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_serializer
// Purpose  : Full-speed USB packet transmitter. Queues bytes in a FIFO, then
//            sends SYNC, bit-stuffed NRZI data (LSB first) and EOP on D+/D-.
// Revision : 1.0  initial release
// ============================================================================
module usb_tx_serializer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int STUFF_LIMIT  = 6,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       d_plus,
    output logic       d_minus,
    output logic       busy,
    output logic       underrun
);
    localparam int c_BCNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_ONES_W = $clog2(STUFF_LIMIT + 1);
    localparam int c_SE0_W  = (EOP_SE0_BITS > 1) ? $clog2(EOP_SE0_BITS) : 1;

    localparam logic [c_BCNT_W-1:0] c_BIT_END = c_BCNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]  c_FULL    = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_ONES_W-1:0] c_STUFF   = c_ONES_W'(STUFF_LIMIT);
    localparam logic [c_SE0_W-1:0]  c_SE0_END = c_SE0_W'(EOP_SE0_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SYNC    = 3'd1,
        S_DATA    = 3'd2,
        S_STUFF   = 3'd3,
        S_EOP_SE0 = 3'd4,
        S_EOP_J   = 3'd5
    } state_t;

    // FIFO entry: {last, data[7:0]}
    logic [8:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] r_last_cnt;

    state_t              r_state;
    logic [c_BCNT_W-1:0] r_bit_cnt;
    logic [2:0]          r_bit_idx;
    logic [c_SE0_W-1:0]  r_se0_cnt;
    logic [c_ONES_W-1:0] r_ones;
    logic [6:0]          r_shift;
    logic                r_cur_last;
    logic                r_line_j;

    logic       w_push;
    logic       w_pop;
    logic [8:0] w_head;
    logic       w_fifo_empty;
    logic       w_start;
    logic       w_strobe;
    logic       w_stuff_due;
    logic       w_at_byte_end;
    logic       w_need_byte;
    logic       w_underrun;
    logic       w_next_bit;
    logic       w_next_line_j;
    logic [c_ONES_W-1:0] w_next_ones;

    assign tx_ready     = (r_count != c_FULL);
    assign w_push       = tx_valid && tx_ready;
    assign w_head       = r_mem[r_rd_ptr];
    assign w_fifo_empty = (r_count == '0);
    assign w_start      = (r_count == c_FULL) || (r_last_cnt != '0);

    // r_bit_idx names the data (or SYNC) bit currently on the line; a stuff
    // bit leaves it untouched so the pending bit resumes afterwards.
    assign w_strobe      = (r_state != S_IDLE) && (r_bit_cnt == c_BIT_END);
    assign w_stuff_due   = (r_state == S_DATA) && (r_ones == c_STUFF);
    assign w_at_byte_end = ((r_state == S_SYNC) || (r_state == S_DATA) || (r_state == S_STUFF))
                           && (r_bit_idx == 3'd7) && !w_stuff_due;
    assign w_need_byte   = w_strobe && w_at_byte_end && !r_cur_last;
    assign w_pop         = w_need_byte && !w_fifo_empty;
    assign w_underrun    = w_need_byte && w_fifo_empty;

    assign w_next_bit    = w_at_byte_end ? w_head[0] : r_shift[0];
    assign w_next_line_j = w_next_bit ? r_line_j : ~r_line_j;
    assign w_next_ones   = w_next_bit ? (r_ones + c_ONES_W'(1)) : '0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {tx_last, tx_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_last_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            case ({w_push && tx_last, w_pop && w_head[8]})
                2'b10:   r_last_cnt <= r_last_cnt + c_CNT_W'(1);
                2'b01:   r_last_cnt <= r_last_cnt - c_CNT_W'(1);
                default: r_last_cnt <= r_last_cnt;
            endcase
        end
    end

    // Every transition happens on a bit strobe and already drives the next
    // line symbol, so each state describes the bit currently on the wire.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_bit_idx  <= '0;
            r_se0_cnt  <= '0;
            r_ones     <= '0;
            r_shift    <= '0;
            r_cur_last <= 1'b0;
            r_line_j   <= 1'b1;
            d_plus     <= 1'b1;
            d_minus    <= 1'b0;
            busy       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            underrun <= w_underrun;
            if ((r_state == S_IDLE) || w_strobe) begin
                r_bit_cnt <= '0;
            end else begin
                r_bit_cnt <= r_bit_cnt + c_BCNT_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        // SYNC bit 0 is a 0: toggle J -> K
                        r_state    <= S_SYNC;
                        r_bit_idx  <= '0;
                        r_ones     <= '0;
                        r_cur_last <= 1'b0;
                        busy       <= 1'b1;
                        r_line_j   <= 1'b0;
                        d_plus     <= 1'b0;
                        d_minus    <= 1'b1;
                    end
                end
                S_SYNC, S_DATA, S_STUFF: begin
                    if (w_strobe) begin
                        if ((r_state == S_SYNC) && (r_bit_idx != 3'd7)) begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            if (r_bit_idx == 3'd6) begin
                                r_ones <= c_ONES_W'(1);
                            end else begin
                                r_line_j <= ~r_line_j;
                                d_plus   <= ~r_line_j;
                                d_minus  <= r_line_j;
                            end
                        end else if (w_stuff_due) begin
                            r_state  <= S_STUFF;
                            r_ones   <= '0;
                            r_line_j <= ~r_line_j;
                            d_plus   <= ~r_line_j;
                            d_minus  <= r_line_j;
                        end else if (w_at_byte_end && (r_cur_last || w_fifo_empty)) begin
                            r_state   <= S_EOP_SE0;
                            r_se0_cnt <= '0;
                            d_plus    <= 1'b0;
                            d_minus   <= 1'b0;
                        end else begin
                            r_state  <= S_DATA;
                            r_ones   <= w_next_ones;
                            r_line_j <= w_next_line_j;
                            d_plus   <= w_next_line_j;
                            d_minus  <= ~w_next_line_j;
                            if (w_at_byte_end) begin
                                r_shift    <= w_head[7:1];
                                r_cur_last <= w_head[8];
                                r_bit_idx  <= '0;
                            end else begin
                                r_shift   <= {1'b0, r_shift[6:1]};
                                r_bit_idx <= r_bit_idx + 3'd1;
                            end
                        end
                    end
                end
                S_EOP_SE0: begin
                    if (w_strobe) begin
                        if (r_se0_cnt == c_SE0_END) begin
                            r_state  <= S_EOP_J;
                            r_line_j <= 1'b1;
                            d_plus   <= 1'b1;
                            d_minus  <= 1'b0;
                        end else begin
                            r_se0_cnt <= r_se0_cnt + c_SE0_W'(1);
                        end
                    end
                end
                S_EOP_J: begin
                    if (w_strobe) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
